// File: rtl/multi_reg_pkg.sv
// multi_reg_pkg
//   Shared constants and types for the multi-port register bank.
//   - DEF_* : default geometry (address width, data width, read ports, PC step)
//   - PC_RESET : value the PC takes on Clr
//   - wr_port_t : one write-port bundle (enable, address, data). Fields are
//     sized for the largest supported geometry (ADDR <= 8, SIZE <= 64); users
//     zero-extend into it and cast back down to their own widths.
package multi_reg_pkg;

  localparam int DEF_ADDR    = 5;
  localparam int DEF_SIZE    = 32;
  localparam int DEF_NRD     = 3;
  localparam int DEF_PC_STEP = 4;

  localparam int MAX_ADDR_W  = 8;
  localparam int MAX_SIZE_W  = 64;

  localparam logic [MAX_SIZE_W-1:0] PC_RESET = '0;

  typedef struct packed {
    logic                  en;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_SIZE_W-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/pc_unit.sv
// pc_unit
//   Program counter register with load/increment priority:
//   clr -> PC_RESET, else load -> load_value, else inc -> pc + STEP
//   (wraps modulo 2**SIZE), else hold.
// Ports:
//   clk        : clock, rising edge
//   clr        : synchronous active-high reset
//   load       : load pc from load_value
//   load_value : new pc value, taken without alignment check
//   inc        : advance pc by STEP
//   pc         : registered pc
module pc_unit
  import multi_reg_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int STEP = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  input  logic            inc,
  output logic [SIZE-1:0] pc
);

  logic [SIZE-1:0] pc_q;
  logic [SIZE-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + SIZE'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= SIZE'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/multi_reg_bank.sv
// multi_reg_bank
//   Register file with NRD combinational read ports, two write ports (A has
//   priority on an address collision), a per-register busy scoreboard and an
//   integrated PC (pc_unit). Register 0 reads as zero and ignores writes and
//   busy marks.
// Optional feature (macro MULTI_REG_BYPASS_EN):
//   defined   : a read whose address matches an enabled same-cycle write
//               returns the write data combinationally (A before B); its
//               R_Busy reads 0 unless Busy_Set targets that address now.
//   undefined : reads see stored state only.
// Ports:
//   Clk, Clr                     : clock, synchronous active-high reset
//   R_Addr / R_Data / R_Busy     : packed read ports, port i in slice i
//   Write_Reg_A/W_Addr_A/W_Data_A: write port A
//   Write_Reg_B/W_Addr_B/W_Data_B: write port B
//   Busy_Set, Busy_Addr          : mark a register as pending writeback
//   Write_PC, PC_New, PC_Inc, PC : program counter control and value
module multi_reg_bank
  import multi_reg_pkg::*;
#(
  parameter int ADDR    = DEF_ADDR,
  parameter int SIZE    = DEF_SIZE,
  parameter int NRD     = DEF_NRD,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [NRD*ADDR-1:0] R_Addr,
  output logic [NRD*SIZE-1:0] R_Data,
  output logic [NRD-1:0]      R_Busy,
  input  logic                Write_Reg_A,
  input  logic [ADDR-1:0]     W_Addr_A,
  input  logic [SIZE-1:0]     W_Data_A,
  input  logic                Write_Reg_B,
  input  logic [ADDR-1:0]     W_Addr_B,
  input  logic [SIZE-1:0]     W_Data_B,
  input  logic                Busy_Set,
  input  logic [ADDR-1:0]     Busy_Addr,
  input  logic                Write_PC,
  input  logic [SIZE-1:0]     PC_New,
  input  logic                PC_Inc,
  output logic [SIZE-1:0]     PC
);

  localparam int NUMB = 2 ** ADDR;

  logic [SIZE-1:0] regs [NUMB];
  logic [NUMB-1:0] busy;

  wr_port_t wr_a;
  wr_port_t wr_b;
  logic     bset_en;

  // Write bundles are qualified here: address 0 is dropped, and address/data
  // of a disabled port are forced to zero so they cannot leak X downstream.
  always_comb begin
    wr_a      = '0;
    wr_a.en   = Write_Reg_A && (W_Addr_A != '0);
    if (wr_a.en) begin
      wr_a.addr = MAX_ADDR_W'(W_Addr_A);
      wr_a.data = MAX_SIZE_W'(W_Data_A);
    end
    wr_b      = '0;
    wr_b.en   = Write_Reg_B && (W_Addr_B != '0);
    if (wr_b.en) begin
      wr_b.addr = MAX_ADDR_W'(W_Addr_B);
      wr_b.data = MAX_SIZE_W'(W_Data_B);
    end
  end

  assign bset_en = Busy_Set && (Busy_Addr != '0);

  // Ordering inside the else branch carries the priorities: port A is
  // assigned after port B so it wins a collision, and the busy set comes
  // after both clears so a new producer supersedes a retiring one.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < NUMB; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_b.en) begin
        regs[ADDR'(wr_b.addr)] <= SIZE'(wr_b.data);
        busy[ADDR'(wr_b.addr)] <= 1'b0;
      end
      if (wr_a.en) begin
        regs[ADDR'(wr_a.addr)] <= SIZE'(wr_a.data);
        busy[ADDR'(wr_a.addr)] <= 1'b0;
      end
      if (bset_en) begin
        busy[Busy_Addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR-1:0] ra;
    logic [SIZE-1:0] rdat;
    logic            rbsy;

    assign ra = R_Addr[i*ADDR +: ADDR];

    always_comb begin
      rdat = '0;
      rbsy = 1'b0;
      if (ra != '0) begin
        rdat = regs[ra];
        rbsy = busy[ra];
      end
`ifdef MULTI_REG_BYPASS_EN
      // wr_x.en already excludes address 0, so the register-0 guard holds.
      if (wr_a.en && (ADDR'(wr_a.addr) == ra)) begin
        rdat = SIZE'(wr_a.data);
        rbsy = bset_en && (Busy_Addr == ra);
      end else if (wr_b.en && (ADDR'(wr_b.addr) == ra)) begin
        rdat = SIZE'(wr_b.data);
        rbsy = bset_en && (Busy_Addr == ra);
      end
`endif
    end

    assign R_Data[i*SIZE +: SIZE] = rdat;
    assign R_Busy[i]              = rbsy;
  end

  pc_unit #(
    .SIZE (SIZE),
    .STEP (PC_STEP)
  ) u_pc (
    .clk        (Clk),
    .clr        (Clr),
    .load       (Write_PC),
    .load_value (PC_New),
    .inc        (PC_Inc),
    .pc         (PC)
  );

endmodule

// File: tb/tb_multi_reg_bank.sv
// tb_multi_reg_bank
//   Directed bench for multi_reg_bank at default geometry (ADDR=5, SIZE=32,
//   NRD=3, PC_STEP=4). Expected values are written out by hand; bypass
//   dependent expectations follow MULTI_REG_BYPASS_EN.
module tb_multi_reg_bank;

  localparam int ADDR = 5;
  localparam int SIZE = 32;
  localparam int NRD  = 3;

  logic                Clk;
  logic                Clr;
  logic [NRD*ADDR-1:0] R_Addr;
  logic [NRD*SIZE-1:0] R_Data;
  logic [NRD-1:0]      R_Busy;
  logic                Write_Reg_A;
  logic [ADDR-1:0]     W_Addr_A;
  logic [SIZE-1:0]     W_Data_A;
  logic                Write_Reg_B;
  logic [ADDR-1:0]     W_Addr_B;
  logic [SIZE-1:0]     W_Data_B;
  logic                Busy_Set;
  logic [ADDR-1:0]     Busy_Addr;
  logic                Write_PC;
  logic [SIZE-1:0]     PC_New;
  logic                PC_Inc;
  logic [SIZE-1:0]     PC;

  int n_checks = 0;
  int n_errors = 0;

  multi_reg_bank dut (
    .Clk         (Clk),
    .Clr         (Clr),
    .R_Addr      (R_Addr),
    .R_Data      (R_Data),
    .R_Busy      (R_Busy),
    .Write_Reg_A (Write_Reg_A),
    .W_Addr_A    (W_Addr_A),
    .W_Data_A    (W_Data_A),
    .Write_Reg_B (Write_Reg_B),
    .W_Addr_B    (W_Addr_B),
    .W_Data_B    (W_Data_B),
    .Busy_Set    (Busy_Set),
    .Busy_Addr   (Busy_Addr),
    .Write_PC    (Write_PC),
    .PC_New      (PC_New),
    .PC_Inc      (PC_Inc),
    .PC          (PC)
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Write_Reg_A = 1'b0; W_Addr_A = '0; W_Data_A = '0;
    Write_Reg_B = 1'b0; W_Addr_B = '0; W_Data_B = '0;
    Busy_Set    = 1'b0; Busy_Addr = '0;
    Write_PC    = 1'b0; PC_New = '0; PC_Inc = 1'b0;
  endtask

  task automatic set_raddr(input logic [ADDR-1:0] a0, input logic [ADDR-1:0] a1,
                           input logic [ADDR-1:0] a2);
    R_Addr = {a2, a1, a0};
  endtask

  function automatic logic [SIZE-1:0] rd(input int i);
    return R_Data[i*SIZE +: SIZE];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Clr = 1'b1;
    idle_inputs();
    set_raddr(5'd0, 5'd8, 5'd13);

    // reset for two cycles
    step();
    step();
    check("reset_pc", PC, 32'h0);
    check("reset_rd1", rd(1), 32'h0);
    check("reset_busy", R_Busy, 3'b000);

    // dual write, different addresses
    Clr = 1'b0;
    Write_Reg_A = 1'b1; W_Addr_A = 5'd8;  W_Data_A = 32'd2;
    Write_Reg_B = 1'b1; W_Addr_B = 5'd13; W_Data_B = 32'd3;
    step();
    idle_inputs();
    check("dual_rd0", rd(0), 32'd0);
    check("dual_rd1", rd(1), 32'd2);
    check("dual_rd2", rd(2), 32'd3);
    check("dual_pc", PC, 32'h0);

    // same-address collision: A wins
    Write_Reg_A = 1'b1; W_Addr_A = 5'd5; W_Data_A = 32'h11;
    Write_Reg_B = 1'b1; W_Addr_B = 5'd5; W_Data_B = 32'h22;
    step();
    idle_inputs();
    set_raddr(5'd5, 5'd5, 5'd8);
    #1;
    check("collide_rd0", rd(0), 32'h11);
    check("collide_rd1", rd(1), 32'h11);
    check("collide_keep8", rd(2), 32'd2);

    // register 0 guard
    Write_Reg_A = 1'b1; W_Addr_A = 5'd0; W_Data_A = 32'hDEAD;
    Busy_Set = 1'b1; Busy_Addr = 5'd0;
    set_raddr(5'd0, 5'd0, 5'd0);
    step();
    idle_inputs();
    check("r0_data", rd(0), 32'h0);
    check("r0_busy", R_Busy, 3'b000);

    // scoreboard: set, then busy is visible only after the edge
    set_raddr(5'd7, 5'd9, 5'd0);
    Busy_Set = 1'b1; Busy_Addr = 5'd7;
    #1;
    check("busy_before_edge", R_Busy, 3'b000);
    step();
    idle_inputs();
    check("busy_set7", R_Busy, 3'b001);

    // write + set same register: set wins
    Write_Reg_A = 1'b1; W_Addr_A = 5'd7; W_Data_A = 32'h77;
    Busy_Set = 1'b1; Busy_Addr = 5'd7;
    step();
    idle_inputs();
    check("busy_set_wins", R_Busy, 3'b001);
    check("data7_a", rd(0), 32'h77);

    // write alone clears busy
    Write_Reg_A = 1'b1; W_Addr_A = 5'd7; W_Data_A = 32'h78;
    step();
    idle_inputs();
    check("busy_clr_a", R_Busy, 3'b000);
    check("data7_b", rd(0), 32'h78);

    // port B write also clears busy
    Busy_Set = 1'b1; Busy_Addr = 5'd9;
    step();
    idle_inputs();
    check("busy_set9", R_Busy, 3'b010);
    Write_Reg_B = 1'b1; W_Addr_B = 5'd9; W_Data_B = 32'h99;
    step();
    idle_inputs();
    check("busy_clr_b", R_Busy, 3'b000);
    check("data9", rd(1), 32'h99);

    // PC: load beats increment, then wrap
    Write_PC = 1'b1; PC_New = 32'hFFFF_FFF8; PC_Inc = 1'b1;
    step();
    check("pc_load", PC, 32'hFFFF_FFF8);
    Write_PC = 1'b0; PC_New = 32'h1234_5678;
    step();
    check("pc_inc1", PC, 32'hFFFF_FFFC);
    step();
    check("pc_wrap", PC, 32'h0000_0000);
    step();
    check("pc_inc3", PC, 32'h0000_0004);
    PC_Inc = 1'b0;
    step();
    check("pc_hold", PC, 32'h0000_0004);

    // Clr mid-sequence overrides everything
    PC_Inc = 1'b1;
    Write_Reg_A = 1'b1; W_Addr_A = 5'd8; W_Data_A = 32'hABCD;
    Busy_Set = 1'b1; Busy_Addr = 5'd9;
    Clr = 1'b1;
    set_raddr(5'd8, 5'd9, 5'd13);
    step();
    Clr = 1'b0;
    idle_inputs();
    #1;
    check("clr_pc", PC, 32'h0);
    check("clr_rd0", rd(0), 32'h0);
    check("clr_rd2", rd(2), 32'h0);
    check("clr_busy", R_Busy, 3'b000);

    // bypass behaviour (same-cycle read of a write in flight)
    set_raddr(5'd3, 5'd4, 5'd0);
    Write_Reg_A = 1'b1; W_Addr_A = 5'd3; W_Data_A = 32'h55;
    Write_Reg_B = 1'b1; W_Addr_B = 5'd4; W_Data_B = 32'h66;
    #1;
`ifdef MULTI_REG_BYPASS_EN
    check("bypass_a", rd(0), 32'h55);
    check("bypass_b", rd(1), 32'h66);
`else
    check("nobypass_a", rd(0), 32'h0);
    check("nobypass_b", rd(1), 32'h0);
`endif
    step();
    idle_inputs();
    check("post_write3", rd(0), 32'h55);
    check("post_write4", rd(1), 32'h66);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
